// File: rtl/lag_peak_search_if.sv
// Correlation sample stream: valid/ready handshake with a start-of-frame marker.
// The source drives valid/sof/data; the sink returns ready.
interface lag_peak_search_if #(
  parameter int DW = 32
);
  logic                 corr_valid;
  logic                 corr_sof;
  logic signed [DW-1:0] corr_data;
  logic                 corr_ready;

  modport master (output corr_valid, corr_sof, corr_data, input corr_ready);
  modport slave  (input corr_valid, corr_sof, corr_data, output corr_ready);
endinterface

// File: rtl/lag_peak_search.sv
// Per-pair argmax over a 2*MAXLAG+1 lag window; lag_diff/lag_valid appear 1 cycle after the last sample.
// Backpressure: corr_ready drops only for the single COMMIT cycle following each complete frame.
module lag_peak_search #(
  parameter int DW     = 32,
  parameter int MAXLAG = 8,
  parameter int NPAIR  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lag_peak_search_if.slave       corr,
  output logic [NPAIR-1:0][31:0] lag_diff,
  output logic                   lag_valid,
  output logic                   frame_err
);

  localparam int W  = 2 * MAXLAG + 1;
  localparam int IW = $clog2(W);
  localparam int PW = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]           state;
  logic [IW-1:0]        lag_cnt;
  logic [PW-1:0]        pair_cnt;
  logic signed [DW-1:0] best_val;
  logic [IW-1:0]        best_idx;
  logic [31:0]          shadow [NPAIR];

  logic                 accept;
  logic                 proc;
  logic                 abort;
  logic [IW-1:0]        eff_lag;
  logic [PW-1:0]        eff_pair;
  logic                 lag_last;
  logic                 frame_last;
  logic                 take;
  logic signed [DW-1:0] nxt_val;
  logic [IW-1:0]        nxt_idx;
  logic [31:0]          peak_lag;

  assign corr.corr_ready = (state != S_COMMIT);

  // A sample carrying sof always restarts at (pair 0, lag 0), whether from IDLE or mid-frame.
  always_comb begin
    accept     = corr.corr_valid && corr.corr_ready;
    proc       = accept && (corr.corr_sof || (state == S_ACCUM));
    abort      = accept && corr.corr_sof && (state == S_ACCUM) &&
                 ((pair_cnt != '0) || (lag_cnt != '0));
    eff_lag    = corr.corr_sof ? '0 : lag_cnt;
    eff_pair   = corr.corr_sof ? '0 : pair_cnt;
    lag_last   = (eff_lag == IW'(W - 1));
    frame_last = lag_last && (eff_pair == PW'(NPAIR - 1));
    take       = (eff_lag == '0) || (corr.corr_data > best_val);
    nxt_val    = take ? corr.corr_data : best_val;
    nxt_idx    = take ? eff_lag : best_idx;
    peak_lag   = 32'(nxt_idx) - 32'(MAXLAG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      lag_cnt  <= '0;
      pair_cnt <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else begin
      case (state)
        S_IDLE:   if (proc) state <= frame_last ? S_COMMIT : S_ACCUM;
        S_ACCUM:  if (proc && frame_last) state <= S_COMMIT;
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      if (proc) begin
        best_val <= nxt_val;
        best_idx <= nxt_idx;
        if (lag_last) begin
          lag_cnt  <= '0;
          pair_cnt <= frame_last ? '0 : eff_pair + 1'b1;
        end else begin
          lag_cnt  <= eff_lag + 1'b1;
          pair_cnt <= eff_pair;
        end
      end
    end
  end

  // The last pair's result bypasses shadow so lag_diff is complete in the COMMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lag_diff  <= '0;
      lag_valid <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < NPAIR; i++) shadow[i] <= '0;
    end else begin
      lag_valid <= proc && frame_last;
      frame_err <= abort;
      for (int i = 0; i < NPAIR; i++) begin
        if (abort)
          shadow[i] <= '0;
        else if (proc && lag_last && (eff_pair == PW'(i)))
          shadow[i] <= peak_lag;
        if (proc && frame_last)
          lag_diff[i] <= (eff_pair == PW'(i)) ? peak_lag : shadow[i];
      end
    end
  end

endmodule

// File: tb/tb_lag_peak_search.sv
// Directed bench for lag_peak_search: single peaks, ties/negatives, gaps, early sof,
// back-to-back frames and mid-frame reset, with hand-computed expected lags.
module tb_lag_peak_search;
  localparam int NP = 6;
  localparam int ML = 8;
  localparam int W  = 2 * ML + 1;
  localparam int FL = NP * W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NP-1:0][31:0] lag_diff;
  logic                lag_valid;
  logic                frame_err;

  lag_peak_search_if #(.DW(32)) corr_bus ();

  lag_peak_search #(.DW(32), .MAXLAG(ML), .NPAIR(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .corr      (corr_bus),
    .lag_diff  (lag_diff),
    .lag_valid (lag_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lv_cnt  = 0;
  int fe_cnt  = 0;
  int lv_cyc  = -1;
  int acc_cyc = 0;
  int rejects = 0;
  int fr [FL];
  int exp_single [NP] = '{-8, -3, 0, 2, 5, 8};
  int exp_mix    [NP] = '{-2, 7, -5, -8, 1, -1};
  int exp_zero   [NP] = '{0, 0, 0, 0, 0, 0};

  always @(negedge clk) begin
    cyc++;
    if (lag_valid) begin
      lv_cnt++;
      lv_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic check_diff(input string tag, input int e [NP]);
    for (int p = 0; p < NP; p++)
      chk($sformatf("%s_lag_diff[%0d]", tag, p), lag_diff[p], e[p]);
  endtask

  task automatic fill_single();
    for (int i = 0; i < FL; i++) fr[i] = 0;
    for (int p = 0; p < NP; p++) fr[p * W + exp_single[p] + ML] = 1000;
  endtask

  task automatic fill_mix();
    for (int i = 0; i < FL; i++) fr[i] = 0;
    for (int l = 0; l < W; l++) begin
      fr[l]         = -50;
      fr[W + l]     = -100 - 10 * ((l > 15) ? (l - 15) : (15 - l));
      fr[2 * W + l] = -2000000000;
    end
    fr[6]          = -10;
    fr[12]         = -10;
    fr[2 * W + 3]  = 2000000000;
    fr[4 * W + 9]  = 1000;
    fr[5 * W + 7]  = 5;
    fr[5 * W + 14] = 5;
  endtask

  // Offer one sample, holding it until accepted; optional random idle cycles before it.
  task automatic send(input logic sof, input int data, input int gap_pct);
    int   waits;
    logic acc;
    waits = 0;
    acc   = 1'b0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      @(negedge clk);
      corr_bus.corr_valid = 1'b0;
      corr_bus.corr_sof   = 1'b0;
      @(posedge clk);
    end
    while (!acc && waits < 20) begin
      @(negedge clk);
      corr_bus.corr_valid = 1'b1;
      corr_bus.corr_sof   = sof;
      corr_bus.corr_data  = data;
      acc = corr_bus.corr_ready;
      @(posedge clk);
      if (!acc) waits++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    acc_cyc = cyc;
    rejects += waits;
  endtask

  task automatic send_range(input int lo, input int hi, input logic sof_first, input int gap_pct);
    for (int i = lo; i < hi; i++) send(sof_first && (i == lo), fr[i], gap_pct);
  endtask

  task automatic idle();
    @(negedge clk);
    corr_bus.corr_valid = 1'b0;
    corr_bus.corr_sof   = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lv0;
    int fe0;
    corr_bus.corr_valid = 1'b0;
    corr_bus.corr_sof   = 1'b0;
    corr_bus.corr_data  = '0;
    settle(3);
    chk("rst_ready", corr_bus.corr_ready, 1);
    chk("rst_lag_valid", lag_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    check_diff("rst", exp_zero);
    @(negedge clk);
    rst_n = 1'b1;

    // Single peak per pair, back-to-back samples
    fill_single();
    lv0 = lv_cnt;
    send_range(0, FL, 1'b1, 0);
    #1;
    chk("t1_commit_ready", corr_bus.corr_ready, 0);
    chk("t1_lag_valid_now", lag_valid, 1);
    idle();
    settle(2);
    chk("t1_pulses", lv_cnt - lv0, 1);
    chk("t1_latency", lv_cyc, acc_cyc + 1);
    check_diff("t1", exp_single);

    // Ties, negative windows, full-width signed compare
    fill_mix();
    lv0 = lv_cnt;
    send_range(0, FL, 1'b1, 0);
    idle();
    settle(2);
    chk("t2_pulses", lv_cnt - lv0, 1);
    chk("t2_latency", lv_cyc, acc_cyc + 1);
    check_diff("t2", exp_mix);

    // Same single-peak frame with ~30% idle cycles
    fill_single();
    lv0 = lv_cnt;
    send_range(0, FL, 1'b1, 30);
    idle();
    settle(2);
    chk("t3_pulses", lv_cnt - lv0, 1);
    chk("t3_latency", lv_cyc, acc_cyc + 1);
    check_diff("t3", exp_single);

    // Early sof at pair 3, lag 4 (sample 55), then the restarted frame completes
    fill_mix();
    lv0 = lv_cnt;
    fe0 = fe_cnt;
    send_range(0, 3 * W + 4, 1'b1, 0);
    idle();
    settle(2);
    chk("t4_no_err_yet", fe_cnt - fe0, 0);
    send_range(0, FL, 1'b1, 0);
    idle();
    settle(2);
    chk("t4_frame_err", fe_cnt - fe0, 1);
    chk("t4_pulses", lv_cnt - lv0, 1);
    check_diff("t4", exp_mix);

    fill_single();
    lv0 = lv_cnt;
    fe0 = fe_cnt;
    send_range(0, 55, 1'b1, 0);
    send(1'b1, fr[0], 0);
    idle();
    settle(2);
    chk("t4b_frame_err", fe_cnt - fe0, 1);
    chk("t4b_no_commit", lv_cnt - lv0, 0);
    check_diff("t4b_held", exp_mix);
    send_range(1, FL, 1'b0, 0);
    idle();
    settle(2);
    chk("t4b_pulses", lv_cnt - lv0, 1);
    check_diff("t4b", exp_single);

    // Back-to-back frames: first sample of frame B is refused during COMMIT
    lv0 = lv_cnt;
    rejects = 0;
    fill_single();
    send_range(0, FL, 1'b1, 0);
    fill_mix();
    send_range(0, FL, 1'b1, 0);
    idle();
    settle(2);
    chk("t5_rejects", rejects, 1);
    chk("t5_pulses", lv_cnt - lv0, 2);
    chk("t5_latency", lv_cyc, acc_cyc + 1);
    check_diff("t5", exp_mix);

    // Reset after 40 samples, then non-sof samples must be dropped
    fill_single();
    lv0 = lv_cnt;
    send_range(0, 40, 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    corr_bus.corr_valid = 1'b0;
    settle(2);
    chk("t6_rst_lag_valid", lag_valid, 0);
    chk("t6_rst_frame_err", frame_err, 0);
    chk("t6_rst_ready", corr_bus.corr_ready, 1);
    check_diff("t6_rst", exp_zero);
    @(negedge clk);
    rst_n = 1'b1;
    send_range(0, FL, 1'b0, 0);
    idle();
    settle(2);
    chk("t6_dropped", lv_cnt - lv0, 0);
    check_diff("t6_dropped", exp_zero);
    fill_mix();
    send_range(0, FL, 1'b1, 0);
    idle();
    settle(2);
    chk("t6_pulses", lv_cnt - lv0, 1);
    check_diff("t6", exp_mix);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end

endmodule
